// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package elastic_pipe_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int STAGES_MAX = 16;

  // Width needed to count 0..stages valid entries.
  function automatic int OCC_W(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage: a valid/data register pair with a collapsing ready term.
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              dn_ready,
  input  logic              flush,
  output logic              rdy_o,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // An empty stage can always absorb, so bubbles collapse toward the output.
  assign rdy_o = !valid_q | dn_ready;
  assign valid = valid_q;
  assign data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (rdy_o) begin
      valid_q <= up_valid & !flush;
      if (up_valid) begin
        data_q <= up_data;
      end
    end else if (flush) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// N-stage elastic pipeline with per-stage flush and occupancy reporting.
// Optional stall/bubble counters are enabled by defining ELASTIC_PIPE_PERF_CNT_EN.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         in_data_i,
  input  logic [STAGES-1:0]         flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [OCC_W(STAGES)-1:0]  occupancy_o,
`ifdef ELASTIC_PIPE_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0]     stall_cnt_o,
  output logic [PERF_CNT_W-1:0]     bubble_cnt_o,
`endif
  output logic                      full_o
);

  localparam int OW = OCC_W(STAGES);

  logic              valid [STAGES];
  logic [DATA_W-1:0] data  [STAGES];
  logic              up_v  [STAGES];
  logic [DATA_W-1:0] up_d  [STAGES];
  logic              rdy   [STAGES+1];

  assign rdy[STAGES] = out_ready_i;

  for (genvar i = 0; i < STAGES; i++) begin : stage_g
    if (i == 0) begin : head_g
      assign up_v[i] = in_valid_i;
      assign up_d[i] = in_data_i;
    end else begin : link_g
      assign up_v[i] = valid[i-1];
      assign up_d[i] = data[i-1];
    end

    elastic_pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk_i),
      .rst      (rst_i),
      .up_valid (up_v[i]),
      .up_data  (up_d[i]),
      .dn_ready (rdy[i+1]),
      .flush    (flush_i[i]),
      .rdy_o    (rdy[i]),
      .valid    (valid[i]),
      .data     (data[i])
    );
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = valid[STAGES-1];
  assign out_data_o  = data[STAGES-1];

  always_comb begin
    occupancy_o = '0;
    full_o      = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_o = occupancy_o + OW'(valid[i]);
      full_o      = full_o & valid[i];
    end
  end

`ifdef ELASTIC_PIPE_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (in_valid_i && !in_ready_o && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (out_ready_i && !out_valid_o && bubble_cnt_o != '1) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
